// File: rtl/difftest_commit_buffer_if.sv
// Commit-side and drain-side handshake bundle for the difftest commit buffer.
// slave is the buffer; master is the core/harness side that drives commits and drains records.
interface difftest_commit_buffer_if #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned NR_GPR       = 32,
   parameter int unsigned COMMIT_WIDTH = 2
);
   localparam int unsigned AW = (NR_GPR > 1) ? $clog2(NR_GPR) : 1;

   logic [COMMIT_WIDTH-1:0]      commit_valid;
   logic [COMMIT_WIDTH*XLEN-1:0] commit_pc;
   logic [COMMIT_WIDTH*32-1:0]   commit_inst;
   logic [COMMIT_WIDTH-1:0]      commit_wen;
   logic [COMMIT_WIDTH*AW-1:0]   commit_wdest;
   logic [COMMIT_WIDTH*XLEN-1:0] commit_wdata;
   logic                         commit_ready;

   logic                         out_valid;
   logic                         out_ready;
   logic [XLEN-1:0]              out_pc;
   logic [31:0]                  out_inst;
   logic                         out_wen;
   logic [AW-1:0]                out_wdest;
   logic [XLEN-1:0]              out_wdata;

   modport master (
      output commit_valid, commit_pc, commit_inst, commit_wen, commit_wdest, commit_wdata,
      input  commit_ready,
      input  out_valid, out_pc, out_inst, out_wen, out_wdest, out_wdata,
      output out_ready
   );

   modport slave (
      input  commit_valid, commit_pc, commit_inst, commit_wen, commit_wdest, commit_wdata,
      output commit_ready,
      output out_valid, out_pc, out_inst, out_wen, out_wdest, out_wdata,
      input  out_ready
   );
endinterface

// File: rtl/difftest_commit_buffer.sv
// Multi-channel commit-trace monitor: shadow GPR file updated in commit order, commit records
// queued in a FIFO drained over a valid/ready port, plus retire counter and sticky overflow flag.
module difftest_commit_buffer #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned NR_GPR       = 32,
   parameter int unsigned COMMIT_WIDTH = 2,
   parameter int unsigned DEPTH        = 8,
   localparam int unsigned AW          = (NR_GPR > 1) ? $clog2(NR_GPR) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   difftest_commit_buffer_if.slave bus,
   input  logic [AW-1:0]         gpr_raddr,
   output logic [XLEN-1:0]       gpr_rdata,
   output logic [63:0]           instret,
   output logic                  overflow
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   // Highest occupancy that still leaves room for a full commit group.
   localparam logic [CW-1:0] ReadyMax = CW'(DEPTH - COMMIT_WIDTH);
   localparam logic [AW:0]   NrGpr    = (AW + 1)'(NR_GPR);

   logic [XLEN-1:0] pc_q    [DEPTH];
   logic [XLEN-1:0] pc_d    [DEPTH];
   logic [31:0]     inst_q  [DEPTH];
   logic [31:0]     inst_d  [DEPTH];
   logic            wen_q   [DEPTH];
   logic            wen_d   [DEPTH];
   logic [AW-1:0]   wdest_q [DEPTH];
   logic [AW-1:0]   wdest_d [DEPTH];
   logic [XLEN-1:0] wdata_q [DEPTH];
   logic [XLEN-1:0] wdata_d [DEPTH];

   logic [XLEN-1:0] gpr_q [NR_GPR];
   logic [XLEN-1:0] gpr_d [NR_GPR];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wptr;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] push_cnt;
   logic [63:0]   instret_q, instret_d;
   logic          overflow_q, overflow_d;
   logic          ready;
   logic          pop;
   logic [AW-1:0] dest;

   // Credit comes from registered occupancy only; a pop in this cycle frees nothing yet.
   assign ready            = !reset && (count_q <= ReadyMax);
   assign bus.commit_ready = ready;

   always_comb begin
      pc_d     = pc_q;
      inst_d   = inst_q;
      wen_d    = wen_q;
      wdest_d  = wdest_q;
      wdata_d  = wdata_q;
      gpr_d    = gpr_q;
      wptr     = wr_ptr_q;
      push_cnt = '0;
      dest     = '0;
      // Ascending channel order keeps the FIFO in program order and lets the
      // highest channel win when several write the same register.
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (bus.commit_valid[i] && ready) begin
            dest          = bus.commit_wdest[i*AW +: AW];
            pc_d[wptr]    = bus.commit_pc[i*XLEN +: XLEN];
            inst_d[wptr]  = bus.commit_inst[i*32 +: 32];
            wen_d[wptr]   = bus.commit_wen[i];
            wdest_d[wptr] = dest;
            wdata_d[wptr] = bus.commit_wdata[i*XLEN +: XLEN];
            wptr          = wptr + 1'b1;
            push_cnt      = push_cnt + 1'b1;
            if (bus.commit_wen[i] && (dest != '0) && ({1'b0, dest} < NrGpr)) begin
               gpr_d[dest] = bus.commit_wdata[i*XLEN +: XLEN];
            end
         end
      end
      pop        = (count_q != '0) && bus.out_ready;
      wr_ptr_d   = wptr;
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = count_q + push_cnt - CW'(pop);
      instret_d  = instret_q + 64'(push_cnt);
      overflow_d = overflow_q || ((|bus.commit_valid) && !ready);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         instret_q  <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < NR_GPR; i++) begin
            gpr_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         instret_q  <= instret_d;
         overflow_q <= overflow_d;
         gpr_q      <= gpr_d;
      end
   end

   // Record storage needs no reset: contents are only observed while out_valid is high.
   always_ff @(posedge clock) begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      wen_q   <= wen_d;
      wdest_q <= wdest_d;
      wdata_q <= wdata_d;
   end

   assign bus.out_valid = (count_q != '0);
   assign bus.out_pc    = pc_q[rd_ptr_q];
   assign bus.out_inst  = inst_q[rd_ptr_q];
   assign bus.out_wen   = wen_q[rd_ptr_q];
   assign bus.out_wdest = wdest_q[rd_ptr_q];
   assign bus.out_wdata = wdata_q[rd_ptr_q];

   assign gpr_rdata = ((gpr_raddr != '0) && ({1'b0, gpr_raddr} < NrGpr)) ? gpr_q[gpr_raddr] : '0;
   assign instret   = instret_q;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_difftest_commit_buffer.sv
// Directed bench for difftest_commit_buffer: a vector table for the basic commit/drain flow,
// then hand sequences for fill/overflow, drain credit, pointer wrap and mid-stream reset.
module tb_difftest_commit_buffer;
   localparam int unsigned XLEN  = 64;
   localparam int unsigned NGPR  = 32;
   localparam int unsigned CWID  = 2;
   localparam int unsigned DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  gpr_raddr;
   logic [63:0] gpr_rdata;
   logic [63:0] instret;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   difftest_commit_buffer_if #(.XLEN(XLEN), .NR_GPR(NGPR), .COMMIT_WIDTH(CWID)) bus ();

   difftest_commit_buffer #(
      .XLEN(XLEN), .NR_GPR(NGPR), .COMMIT_WIDTH(CWID), .DEPTH(DEPTH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .gpr_raddr (gpr_raddr),
      .gpr_rdata (gpr_rdata),
      .instret   (instret),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  wen;
      logic [4:0]  d0;
      logic [4:0]  d1;
      logic [63:0] x0;
      logic [63:0] x1;
      logic        ordy;
      logic [4:0]  raddr;
      logic        eov;
      logic        erdy;
      logic [63:0] egpr;
      logic [63:0] eret;
      logic [63:0] ehead;
      logic [4:0]  ehdest;
      logic        ehwen;
   } vec_t;

   vec_t tbl [10];
   logic [63:0] model [$];

   function automatic logic [63:0] pc_of(input logic [63:0] x);
      return 64'h8000_0000 + ((x - 64'd5) << 2);
   endfunction

   function automatic logic [31:0] inst_of(input logic [63:0] x);
      logic [31:0] lo;
      lo = x[31:0];
      return 32'h0050_0093 + (lo - 32'd5);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic v, input logic w, input logic [4:0] d,
                         input logic [63:0] x);
      bus.commit_valid[ch]           = v;
      bus.commit_wen[ch]             = w;
      bus.commit_wdest[ch*5 +: 5]    = d;
      bus.commit_wdata[ch*64 +: 64]  = x;
      bus.commit_pc[ch*64 +: 64]     = pc_of(x);
      bus.commit_inst[ch*32 +: 32]   = inst_of(x);
   endtask

   task automatic idle_inputs();
      set_ch(0, 1'b0, 1'b0, 5'd0, 64'd0);
      set_ch(1, 1'b0, 1'b0, 5'd0, 64'd0);
      bus.out_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model.delete();
   endtask

   task automatic check_head(input string name, input logic [63:0] x);
      check({name, " out_wdata"}, bus.out_wdata, x);
      check({name, " out_pc"}, bus.out_pc, pc_of(x));
      check({name, " out_inst"}, 64'(bus.out_inst), 64'(inst_of(x)));
   endtask

   initial begin
      tbl[0] = '{2'b01, 2'b01, 5'd1, 5'd0, 64'h05, 64'h00, 1'b0, 5'd1,  1'b1, 1'b1, 64'h05, 64'd1, 64'h05, 5'd1, 1'b1};
      tbl[1] = '{2'b11, 2'b11, 5'd3, 5'd3, 64'h0A, 64'h0B, 1'b0, 5'd3,  1'b1, 1'b1, 64'h0B, 64'd3, 64'h05, 5'd1, 1'b1};
      tbl[2] = '{2'b10, 2'b10, 5'd0, 5'd0, 64'h00, 64'hFF, 1'b0, 5'd0,  1'b1, 1'b1, 64'h00, 64'd4, 64'h05, 5'd1, 1'b1};
      tbl[3] = '{2'b00, 2'b00, 5'd0, 5'd0, 64'h00, 64'h00, 1'b1, 5'd1,  1'b1, 1'b1, 64'h05, 64'd4, 64'h0A, 5'd3, 1'b1};
      tbl[4] = '{2'b00, 2'b00, 5'd0, 5'd0, 64'h00, 64'h00, 1'b1, 5'd3,  1'b1, 1'b1, 64'h0B, 64'd4, 64'h0B, 5'd3, 1'b1};
      tbl[5] = '{2'b00, 2'b00, 5'd0, 5'd0, 64'h00, 64'h00, 1'b1, 5'd0,  1'b1, 1'b1, 64'h00, 64'd4, 64'hFF, 5'd0, 1'b1};
      tbl[6] = '{2'b00, 2'b00, 5'd0, 5'd0, 64'h00, 64'h00, 1'b1, 5'd31, 1'b0, 1'b1, 64'h00, 64'd4, 64'h00, 5'd0, 1'b0};
      tbl[7] = '{2'b00, 2'b00, 5'd0, 5'd0, 64'h00, 64'h00, 1'b1, 5'd2,  1'b0, 1'b1, 64'h00, 64'd4, 64'h00, 5'd0, 1'b0};
      tbl[8] = '{2'b11, 2'b10, 5'd4, 5'd4, 64'h77, 64'h66, 1'b1, 5'd4,  1'b1, 1'b1, 64'h66, 64'd6, 64'h77, 5'd4, 1'b0};
      tbl[9] = '{2'b11, 2'b01, 5'd5, 5'd5, 64'h11, 64'h22, 1'b1, 5'd5,  1'b1, 1'b1, 64'h11, 64'd8, 64'h66, 5'd4, 1'b1};

      gpr_raddr = '0;
      idle_inputs();
      reset = 1'b1;
      tick();
      check("reset commit_ready", 64'(bus.commit_ready), 64'd0);
      check("reset out_valid", 64'(bus.out_valid), 64'd0);
      check("reset instret", instret, 64'd0);
      check("reset overflow", 64'(overflow), 64'd0);
      reset = 1'b0;
      #1;
      check("post-reset commit_ready", 64'(bus.commit_ready), 64'd1);

      for (int i = 0; i < 10; i++) begin
         set_ch(0, tbl[i].valid[0], tbl[i].wen[0], tbl[i].d0, tbl[i].x0);
         set_ch(1, tbl[i].valid[1], tbl[i].wen[1], tbl[i].d1, tbl[i].x1);
         bus.out_ready = tbl[i].ordy;
         gpr_raddr     = tbl[i].raddr;
         tick();
         check($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].eov));
         check($sformatf("vec%0d commit_ready", i), 64'(bus.commit_ready), 64'(tbl[i].erdy));
         check($sformatf("vec%0d gpr_rdata", i), gpr_rdata, tbl[i].egpr);
         check($sformatf("vec%0d instret", i), instret, tbl[i].eret);
         check($sformatf("vec%0d overflow", i), 64'(overflow), 64'd0);
         if (tbl[i].eov) begin
            check_head($sformatf("vec%0d", i), tbl[i].ehead);
            check($sformatf("vec%0d out_wdest", i), 64'(bus.out_wdest), 64'(tbl[i].ehdest));
            check($sformatf("vec%0d out_wen", i), 64'(bus.out_wen), 64'(tbl[i].ehwen));
         end
      end

      // Fill with no draining: 4 dual groups reach DEPTH, the 5th overflows.
      do_reset();
      for (int g = 0; g < 4; g++) begin
         set_ch(0, 1'b1, 1'b1, 5'd6, 64'h100 + 64'(2*g));
         set_ch(1, 1'b1, 1'b1, 5'd7, 64'h101 + 64'(2*g));
         model.push_back(64'h100 + 64'(2*g));
         model.push_back(64'h101 + 64'(2*g));
         tick();
         if (g == 2) begin
            check("fill3 commit_ready", 64'(bus.commit_ready), 64'd1);
            check("fill3 instret", instret, 64'd6);
         end
      end
      check("full commit_ready", 64'(bus.commit_ready), 64'd0);
      check("full out_valid", 64'(bus.out_valid), 64'd1);
      check("full instret", instret, 64'd8);
      set_ch(0, 1'b1, 1'b1, 5'd8, 64'h1FF);
      set_ch(1, 1'b1, 1'b1, 5'd8, 64'h1FE);
      gpr_raddr = 5'd8;
      tick();
      check("ovf overflow", 64'(overflow), 64'd1);
      check("ovf instret", instret, 64'd8);
      check("ovf commit_ready", 64'(bus.commit_ready), 64'd0);
      check("ovf gpr8", gpr_rdata, 64'd0);
      check_head("ovf head", model[0]);

      // Drain two with no commits: one pop leaves 7 (still stalled), two leave 6.
      set_ch(0, 1'b0, 1'b0, 5'd0, 64'd0);
      set_ch(1, 1'b0, 1'b0, 5'd0, 64'd0);
      bus.out_ready = 1'b1;
      tick();
      void'(model.pop_front());
      check("drain1 commit_ready", 64'(bus.commit_ready), 64'd0);
      check_head("drain1 head", model[0]);
      tick();
      void'(model.pop_front());
      check("drain2 commit_ready", 64'(bus.commit_ready), 64'd1);
      check_head("drain2 head", model[0]);
      check("drain2 overflow sticky", 64'(overflow), 64'd1);

      // Push one and pop one per cycle so both pointers wrap around the ring.
      for (int k = 0; k < 16; k++) begin
         check_head($sformatf("wrap%0d head", k), model[0]);
         set_ch(0, 1'b1, 1'b1, 5'(k % 31 + 1), 64'h200 + 64'(k));
         bus.out_ready = 1'b1;
         tick();
         model.push_back(64'h200 + 64'(k));
         void'(model.pop_front());
         check($sformatf("wrap%0d commit_ready", k), 64'(bus.commit_ready), 64'd1);
      end
      check("wrap instret", instret, 64'd24);
      gpr_raddr = 5'd16;
      #1;
      check("wrap gpr16", gpr_rdata, 64'h20F);

      // Leave 5 entries queued, then reset while a commit is being presented.
      set_ch(0, 1'b0, 1'b0, 5'd0, 64'd0);
      tick();
      void'(model.pop_front());
      check_head("pre-reset head", model[0]);
      set_ch(0, 1'b1, 1'b1, 5'd9, 64'h333);
      set_ch(1, 1'b1, 1'b1, 5'd10, 64'h444);
      bus.out_ready = 1'b0;
      reset = 1'b1;
      #1;
      check("in-reset commit_ready", 64'(bus.commit_ready), 64'd0);
      tick();
      check("mid-reset out_valid", 64'(bus.out_valid), 64'd0);
      check("mid-reset instret", instret, 64'd0);
      check("mid-reset overflow", 64'(overflow), 64'd0);
      reset = 1'b0;
      idle_inputs();
      #1;
      check("mid-reset commit_ready", 64'(bus.commit_ready), 64'd1);
      for (int r = 0; r < 32; r++) begin
         gpr_raddr = 5'(r);
         #1;
         check($sformatf("mid-reset gpr%0d", r), gpr_rdata, 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
